multi_input_activity_selector: RTL and testbench

//  Generalised input selector for the smart-LED front end. Picks one of NUM_IN serial

---
 rtl/multi_input_activity_selector_if.sv | 26 ++
 rtl/multi_input_activity_selector.sv | 109 ++++++++++
 tb/tb_multi_input_activity_selector.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/multi_input_activity_selector_if.sv
// Bus bundle for the activity selector: candidate inputs, test-mode controls and selection status.
interface multi_input_activity_selector_if #(
  parameter int unsigned NUM_IN = 4
);
  localparam int unsigned IDX_W = $clog2(NUM_IN);

  logic [NUM_IN-1:0] in;
  logic              testmode;
  logic [IDX_W-1:0]  test_sel;
  logic              out;
  logic [IDX_W-1:0]  sel_idx;
  logic              locked;
  logic              switched;

  // Source side: drives the candidate inputs and test controls, observes the selection
  modport master (
    output in, testmode, test_sel,
    input  out, sel_idx, locked, switched
  );

  // Selector side
  modport slave (
    input  in, testmode, test_sel,
    output out, sel_idx, locked, switched
  );
endinterface

// File: rtl/multi_input_activity_selector.sv
// Picks one of NUM_IN serial inputs by rising-edge activity, with idle timeout,
// sticky selection and a forced test mode; forwards the chosen input registered.
module multi_input_activity_selector #(
  parameter int unsigned NUM_IN      = 4,
  parameter int unsigned EDGE_THRESH = 63,
  parameter int unsigned TIMEOUT     = 1024
) (
  input logic                         clk,
  input logic                         rst,
  multi_input_activity_selector_if.slave bus
);
  localparam int unsigned IDX_W  = $clog2(NUM_IN);
  localparam int unsigned CNT_W  = $clog2(EDGE_THRESH + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(EDGE_THRESH);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_IN - 1);

  logic [NUM_IN-1:0] in_q;
  logic [NUM_IN-1:0] edge_det;
  logic [NUM_IN-1:0] qualified;
  logic [CNT_W-1:0]  cnt  [NUM_IN];
  logic [IDLE_W-1:0] idle [NUM_IN];

  logic [IDX_W-1:0]  sel_q;
  logic [IDX_W-1:0]  next_sel;
  logic [31:0]       test_sel_w;
  logic              out_q;
  logic              locked_q;
  logic              switched_q;

  assign test_sel_w = 32'(bus.test_sel);

  // Rising-edge detect and qualification flags from registered state
  always_comb begin
    edge_det  = bus.in & ~in_q;
    qualified = '0;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      qualified[i] = (cnt[i] == CNT_MAX);
    end
  end

  // Per-channel edge counter and idle timer; an edge beats a simultaneous timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q <= '0;
      for (int i = 0; i < int'(NUM_IN); i++) begin
        cnt[i]  <= '0;
        idle[i] <= '0;
      end
    end else begin
      in_q <= bus.in;
      for (int i = 0; i < int'(NUM_IN); i++) begin
        if (edge_det[i]) begin
          idle[i] <= '0;
          if (cnt[i] < CNT_MAX) begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          if (idle[i] != IDLE_MAX) begin
            idle[i] <= idle[i] + 1'b1;
          end
          // Idle reaches TIMEOUT on this clock: drop the qualification
          if (idle[i] >= IDLE_LAST) begin
            cnt[i] <= '0;
          end
        end
      end
    end
  end

  // Next selection: forced index, else sticky current, else lowest qualified, else fallback
  always_comb begin
    next_sel = LAST_IDX;
    if (bus.testmode) begin
      next_sel = (test_sel_w > 32'(NUM_IN - 1)) ? LAST_IDX : bus.test_sel;
    end else if (qualified[sel_q]) begin
      next_sel = sel_q;
    end else begin
      for (int i = int'(NUM_IN) - 1; i >= 0; i--) begin
        if (qualified[i]) begin
          next_sel = IDX_W'(i);
        end
      end
    end
  end

  // Registered selection and forwarded data
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q      <= LAST_IDX;
      out_q      <= 1'b0;
      locked_q   <= 1'b0;
      switched_q <= 1'b0;
    end else begin
      sel_q      <= next_sel;
      out_q      <= bus.in[next_sel];
      locked_q   <= !bus.testmode && qualified[next_sel];
      switched_q <= (next_sel != sel_q);
    end
  end

  assign bus.sel_idx  = sel_q;
  assign bus.out      = out_q;
  assign bus.locked   = locked_q;
  assign bus.switched = switched_q;
endmodule

// File: tb/tb_multi_input_activity_selector.sv
// Bench for multi_input_activity_selector: directed scenarios plus randomized traffic,
// every cycle compared against a counting reference model.
module tb_multi_input_activity_selector;
  localparam int N  = 4;
  localparam int TH = 63;
  localparam int TO = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_input_activity_selector_if #(.NUM_IN(N)) bus ();

  multi_input_activity_selector #(
    .NUM_IN(N), .EDGE_THRESH(TH), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: plain counts per input
  int m_edges [N];
  int m_quiet [N];
  bit m_last  [N];
  int m_sel;
  bit m_out, m_locked, m_switched;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled
  function automatic void model_step();
    bit cur [N];
    bit q [N];
    int pick;
    for (int i = 0; i < N; i++) cur[i] = bus.in[i];
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_edges[i] = 0; m_quiet[i] = 0; m_last[i] = 0;
      end
      m_sel = N - 1; m_out = 0; m_locked = 0; m_switched = 0;
      return;
    end
    for (int i = 0; i < N; i++) q[i] = (m_edges[i] == TH);
    if (bus.testmode) begin
      pick = (int'(bus.test_sel) > N - 1) ? N - 1 : int'(bus.test_sel);
    end else if (q[m_sel]) begin
      pick = m_sel;
    end else begin
      pick = -1;
      for (int i = 0; i < N; i++) if (q[i] && pick < 0) pick = i;
      if (pick < 0) pick = N - 1;
    end
    m_out      = cur[pick];
    m_locked   = !bus.testmode && q[pick];
    m_switched = (pick != m_sel);
    m_sel      = pick;
    for (int i = 0; i < N; i++) begin
      if (cur[i] && !m_last[i]) begin
        m_quiet[i] = 0;
        if (m_edges[i] < TH) m_edges[i]++;
      end else begin
        if (m_quiet[i] < TO) m_quiet[i]++;
        if (m_quiet[i] == TO) m_edges[i] = 0;
      end
      m_last[i] = cur[i];
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("sel_idx", 32'(bus.sel_idx), 32'(m_sel));
    check("out", 32'(bus.out), 32'(m_out));
    check("locked", 32'(bus.locked), 32'(m_locked));
    check("switched", 32'(bus.switched), 32'(m_switched));
  endtask

  task automatic drive(input logic [N-1:0] v, input int n);
    bus.in = v;
    repeat (n) cycle();
  endtask

  // n pulses of period 4 on the inputs in mask
  task automatic pulses(input logic [N-1:0] mask, input int n);
    repeat (n) begin
      drive(mask, 1);
      drive('0, 3);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in = '0;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] v;
    int dens [N];
    rst = 1'b1;
    bus.in = '0;
    bus.testmode = 1'b0;
    bus.test_sel = '0;
    cycle();
    cycle();
    check("reset_sel", 32'(bus.sel_idx), 32'd3);
    check("reset_locked", 32'(bus.locked), 32'd0);
    rst = 1'b0;

    // T1: no qualified input, out tracks in[3]
    for (int c = 0; c < 100; c++) begin
      v = '0;
      v[3] = 1'($urandom_range(1));
      drive(v, 1);
    end
    check("t1_sel", 32'(bus.sel_idx), 32'd3);
    do_reset();

    // T2: qualify in[2]
    pulses(4'b0100, 62);
    check("t2_pre_locked", 32'(bus.locked), 32'd0);
    pulses(4'b0100, 1);
    check("t2_sel", 32'(bus.sel_idx), 32'd2);
    check("t2_locked", 32'(bus.locked), 32'd1);

    // T3: sticky selection, then timeout of in[2]
    pulses(4'b0101, 63);
    check("t3_sticky_sel", 32'(bus.sel_idx), 32'd2);
    pulses(4'b0001, 260);
    check("t3_timeout_sel", 32'(bus.sel_idx), 32'd0);
    check("t3_timeout_locked", 32'(bus.locked), 32'd1);

    // T4: test mode override and release
    do_reset();
    pulses(4'b0010, 63);
    check("t4_sel_auto", 32'(bus.sel_idx), 32'd1);
    bus.testmode = 1'b1;
    bus.test_sel = 2'd3;
    for (int c = 0; c < 6; c++) begin
      v = '0;
      v[3] = 1'($urandom_range(1));
      drive(v, 1);
    end
    check("t4_sel_test", 32'(bus.sel_idx), 32'd3);
    check("t4_locked_test", 32'(bus.locked), 32'd0);
    bus.testmode = 1'b0;
    drive('0, 2);
    check("t4_sel_release", 32'(bus.sel_idx), 32'd1);
    check("t4_locked_release", 32'(bus.locked), 32'd1);

    // T5: edge on the exact timeout clock wins; one cycle later it does not
    do_reset();
    pulses(4'b0010, 63);
    drive('0, 1020);
    drive(4'b0010, 1);
    drive('0, 3);
    check("t5_edge_wins_sel", 32'(bus.sel_idx), 32'd1);
    check("t5_edge_wins_locked", 32'(bus.locked), 32'd1);
    drive('0, 1024);
    drive('0, 2);
    check("t5_timeout_sel", 32'(bus.sel_idx), 32'd3);
    check("t5_timeout_locked", 32'(bus.locked), 32'd0);

    // T6: reset while locked discards all counts
    pulses(4'b0100, 63);
    check("t6_locked", 32'(bus.locked), 32'd1);
    rst = 1'b1;
    bus.in = 4'b1111;
    cycle();
    rst = 1'b0;
    check("t6_rst_sel", 32'(bus.sel_idx), 32'd3);
    check("t6_rst_out", 32'(bus.out), 32'd0);
    drive('0, 1);
    pulses(4'b0100, 62);
    check("t6_relock_early", 32'(bus.locked), 32'd0);
    pulses(4'b0100, 1);
    check("t6_relock_sel", 32'(bus.sel_idx), 32'd2);
    check("t6_relock", 32'(bus.locked), 32'd1);

    // Randomized segments of varying activity, test mode and occasional reset
    for (int s = 0; s < 20; s++) begin
      int len;
      len = int'($urandom_range(1200, 100));
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(3))
          0, 1:    dens[i] = 0;
          2:       dens[i] = 30;
          default: dens[i] = 60;
        endcase
      end
      bus.testmode = ($urandom_range(9) == 0);
      bus.test_sel = 2'($urandom_range(3));
      for (int c = 0; c < len; c++) begin
        for (int i = 0; i < N; i++) v[i] = (int'($urandom_range(99)) < dens[i]);
        rst = ($urandom_range(999) == 0);
        drive(v, 1);
      end
      rst = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
